c499_sec_encoder_ff: RTL and testbench
======================================

Name: c499_sec_encoder_ff

Overview:
- Registered single-error-correcting check-bit generator. It is the transmit side feeding the c499 SEC decoder: 32 data bits, 8 check bits and 1 enable bit, matching decoder inputs N1..N125, N129..N136 and N137.
- Two-stage valid/ready pipeline.
- Programmable one-shot single-bit error injection, used to exercise the decoder's correction path.
- 16-bit count of words sent.

Parameters:
- CNT_W, 16, width of sent-word counter (wraps)

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  input word present
- in_ready  out  1  block can accept a word this cycle
- in_data  in  32  data word
- in_en  in  1  decoder enable bit, passed through (N137)
- out_valid  out  1  codeword present
- out_ready  in  1  downstream accepts codeword
- out_data  out  32  data bits (to N1..N125)
- out_chk  out  8  check bits (to N129..N136)
- out_en  out  1  enable bit
- inj_arm  in  1  pulse: arm one-shot error injection
- inj_pos  in  6  codeword bit to flip: 0-31 data[i], 32-39 chk[i-32], 40-63 none
- inj_pending  out  1  injection armed, not yet applied
- word_cnt  out  CNT_W  codewords accepted downstream (out_valid&&out_ready)

Behaviour:
- Reset (async, active-high): s1/s2 valid=0, all data/chk/en regs=0, inj_pending=0, inj_pos_q=0, word_cnt=0. Outputs read 0 while reset is high. Reset mid-transfer discards in-flight words without emitting them.
- Encoding: code(i), i=0..31, is the i-th 8-bit value of Hamming weight exactly 3 in ascending order (0x07, 0x0B, 0x0D, 0x0E, 0x13, ...). chk[k] = XOR over i of (data[i] & code(i)[k]). All codes are distinct with weight 3, so any single flipped bit gives a unique nonzero syndrome.
- Stage 1: registers in_data/in_en on in_valid&&in_ready.
- Stage 2: registers data, computed chk, en, with injection applied. Drives the outputs directly from flops.
- Advance rules:
  - s2 loads when s1_valid && (!s2_valid || out_ready).
  - s1 loads when in_valid && in_ready.
  - in_ready = !s1_valid || s2 loads this cycle.
  - No combinational path from out_ready to out_* data; in_ready depends combinationally on out_ready.
- Latency: word accepted at edge N appears with out_valid=1 after edge N+1 (2 registers). Throughput is 1 word/cycle with out_ready held 1.
- Stall: out_valid && !out_ready holds out_* stable. s1 may still fill; in_ready then drops.
- Injection:
  - inj_arm=1 sets inj_pending=1 and captures inj_pos into inj_pos_q. A re-arm while pending overwrites the position.
  - On the next s1->s2 transfer with inj_pending=1: if inj_pos_q<40, flip that codeword bit after the chk computation. inj_pending clears whether or not a bit was flipped.
  - inj_arm in the same cycle as a transfer: the transfer uses the old pending state; the new arm sets pending for the following word.
- word_cnt increments on each out_valid&&out_ready and wraps 0xFFFF->0x0000.
- out_en = registered in_en of the same word; never altered by injection.

Test Plan:
- Reset mid-stream: 3 words in flight, pulse reset -> out_valid=0, in_ready=1, word_cnt=0 immediately (async), no stale word emitted after release.
- Encode vectors, out_ready=1, inj idle -> data 0x00000000 gives chk 0x00; 0x00000001 gives 0x07; 0x00000002 gives 0x0B; 0x00000003 gives 0x0C; 0x00000010 gives 0x13; 0xFFFFFFFF gives 0x03. out_valid rises 2 edges after acceptance.
- Backpressure: stream 5 words, out_ready=0 for 4 cycles -> out_* stable, in_ready=0 after s1 fills, all 5 words delivered in order, no duplicates, word_cnt=5.
- Injection: arm inj_pos=5, send 0x00000000 twice -> first out_data=0x00000020, chk=0x00, inj_pending cleared; second word clean. Arm inj_pos=33, send 0x00000001 -> chk=0x05. Arm inj_pos=50 -> word clean, pending cleared.
- Counter wrap: preload via 65536 transfers with out_ready=1 -> word_cnt returns to 0x0000.
- Decoder loopback: feed out_* to c499 through its input flops with random data and random single injections -> corrected decoder output equals original in_data on every word.

Source files
------------

// File: rtl/c499_sec_encoder_ff.sv
// Registered check-bit generator feeding the c499 SEC decoder: 32 data bits, 8 check bits
// and an enable bit, delivered through a two-stage pipeline with one-shot error injection.
module c499_sec_encoder_ff #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [7:0]       out_chk,
    output logic             out_en,
    input  logic             inj_arm,
    input  logic [5:0]       inj_pos,
    output logic             inj_pending,
    output logic [CNT_W-1:0] word_cnt
);

    // Handshake: a word moves across an interface on a rising edge where valid && ready are
    // both high; valid never drops and data never changes while valid is high and ready low.

    // Column i is the i-th 8-bit value of Hamming weight three, ascending; entry 0 sits at the LSB.
    localparam logic [255:0] CODE_TABLE = {
        8'h62, 8'h61, 8'h58, 8'h54, 8'h52, 8'h51, 8'h4C, 8'h4A,
        8'h49, 8'h46, 8'h45, 8'h43, 8'h38, 8'h34, 8'h32, 8'h31,
        8'h2C, 8'h2A, 8'h29, 8'h26, 8'h25, 8'h23, 8'h1C, 8'h1A,
        8'h19, 8'h16, 8'h15, 8'h13, 8'h0E, 8'h0D, 8'h0B, 8'h07
    };

    function automatic logic [7:0] calc_chk(input logic [31:0] d);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 0; i < 32; i++) begin
            if (d[i]) c = c ^ CODE_TABLE[i*8 +: 8];
        end
        return c;
    endfunction

    logic        s1_valid;
    logic [31:0] s1_data;
    logic        s1_en;
    logic [5:0]  inj_pos_q;

    logic        s1_load;
    logic        s2_load;
    logic [39:0] flip_mask;
    logic [39:0] codeword;

    always_comb begin
        s2_load  = s1_valid && (!out_valid || out_ready);
        in_ready = !s1_valid || s2_load;
        s1_load  = in_valid && in_ready;
        flip_mask = 40'd0;
        if (inj_pending && (inj_pos_q < 6'd40)) begin
            flip_mask = 40'd1 << inj_pos_q;
        end
        // The flip is applied after check-bit generation so the decoder sees a true single error.
        codeword = {calc_chk(s1_data), s1_data} ^ flip_mask;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid    <= 1'b0;
            s1_data     <= 32'd0;
            s1_en       <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= 32'd0;
            out_chk     <= 8'd0;
            out_en      <= 1'b0;
            inj_pending <= 1'b0;
            inj_pos_q   <= 6'd0;
            word_cnt    <= '0;
        end else begin
            if (s1_load) begin
                s1_valid <= 1'b1;
                s1_data  <= in_data;
                s1_en    <= in_en;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end

            if (s2_load) begin
                out_valid <= 1'b1;
                out_data  <= codeword[31:0];
                out_chk   <= codeword[39:32];
                out_en    <= s1_en;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            // A transfer in the arming cycle consumes the old pending state; the new arm survives.
            if (inj_arm) begin
                inj_pending <= 1'b1;
                inj_pos_q   <= inj_pos;
            end else if (s2_load) begin
                inj_pending <= 1'b0;
            end

            if (out_valid && out_ready) begin
                word_cnt <= word_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_c499_sec_encoder_ff.sv
// Bench for c499_sec_encoder_ff: directed vectors pushed to an expected queue, a monitor that
// pops on every delivered codeword and also decodes it as the c499 decoder would.
module tb_c499_sec_encoder_ff;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_en;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [7:0]  out_chk;
  logic        out_en;
  logic        inj_arm;
  logic [5:0]  inj_pos;
  logic        inj_pending;
  logic [15:0] word_cnt;

  int n_checks = 0;
  int n_fail = 0;

  // {original data, en, chk, data} of each codeword expected downstream
  logic [72:0] exp_q[$];
  logic [7:0]  tb_codes[32];

  logic        stall_prev = 1'b0;
  logic [40:0] held_word;

  c499_sec_encoder_ff #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_en(in_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_chk(out_chk),
    .out_en(out_en), .inj_arm(inj_arm), .inj_pos(inj_pos), .inj_pending(inj_pending),
    .word_cnt(word_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: act=%0h req=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] tb_chk(input logic [31:0] d);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < 32; i++) if (d[i]) c ^= tb_codes[i];
    return c;
  endfunction

  // driver tasks (all called at posedge + #1)
  task automatic send(input logic [31:0] d, input logic e, input logic [31:0] xd, input logic [7:0] xc);
    logic acc;
    in_valid = 1'b1;
    in_data  = d;
    in_en    = e;
    acc      = 1'b0;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (acc) exp_q.push_back({d, e, xc, xd});
    else check("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic arm(input logic [5:0] pos);
    inj_arm = 1'b1;
    inj_pos = pos;
    @(posedge clk);
    #1;
    inj_arm = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(posedge clk);
    #1;
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [72:0] e;
    logic [7:0]  syn;
    logic [31:0] corr;
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && out_valid) check("stall_stable", {23'd0, out_en, out_chk, out_data}, {23'd0, held_word});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", {32'd0, out_data}, 64'd0 - 64'd1);
        end else begin
          e = exp_q.pop_front();
          check("out_data", 64'(out_data), 64'(e[31:0]));
          check("out_chk", 64'(out_chk), 64'(e[39:32]));
          check("out_en", 64'(out_en), 64'(e[40]));
          syn  = out_chk ^ tb_chk(out_data);
          corr = out_data;
          for (int i = 0; i < 32; i++) if (syn != 8'h00 && tb_codes[i] == syn) corr[i] = ~corr[i];
          check("decode", 64'(corr), 64'(e[72:41]));
        end
      end
      stall_prev = out_valid && !out_ready;
      held_word  = {out_en, out_chk, out_data};
    end
  end

  initial begin
    int n;
    logic [31:0] d;
    logic [5:0]  p;
    logic        en;
    logic [39:0] cw;

    n = 0;
    for (int v = 0; v < 256; v++) begin
      if ($countones(v[7:0]) == 3 && n < 32) begin
        tb_codes[n] = v[7:0];
        n++;
      end
    end

    reset = 1'b1; in_valid = 1'b0; in_data = 32'd0; in_en = 1'b0;
    out_ready = 1'b1; inj_arm = 1'b0; inj_pos = 6'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_word_cnt", 64'(word_cnt), 64'd0);
    check("rst_pending", 64'(inj_pending), 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // encode vectors, hand-computed check bits; latency on the first
    send(32'h00000000, 1'b1, 32'h00000000, 8'h00);
    check("latency_n", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    check("latency_n1", 64'(out_valid), 64'd1);
    send(32'h00000001, 1'b0, 32'h00000001, 8'h07);
    send(32'h00000002, 1'b1, 32'h00000002, 8'h0B);
    send(32'h00000003, 1'b0, 32'h00000003, 8'h0C);
    send(32'h00000010, 1'b1, 32'h00000010, 8'h13);
    send(32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 8'h03);
    drain();
    check("cnt_after_encode", 64'(word_cnt), 64'd6);

    // reset mid-stream with words in flight
    out_ready = 1'b0;
    send(32'hAAAA0001, 1'b1, 32'hAAAA0001, 8'h00);
    send(32'hAAAA0002, 1'b1, 32'hAAAA0002, 8'h00);
    in_valid = 1'b1; in_data = 32'hAAAA0003;
    #3;
    reset = 1'b1;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_word_cnt", 64'(word_cnt), 64'd0);
    exp_q.delete();
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("post_rst_idle", 64'(out_valid), 64'd0);

    // backpressure: 5 words, 4 stalled cycles
    out_ready = 1'b0;
    send(32'h11111111, 1'b1, 32'h11111111, tb_chk(32'h11111111));
    send(32'h22222222, 1'b0, 32'h22222222, tb_chk(32'h22222222));
    in_valid = 1'b1; in_data = 32'h33333333;
    @(negedge clk);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    fork
      send(32'h33333333, 1'b1, 32'h33333333, tb_chk(32'h33333333));
      begin
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    send(32'h44444444, 1'b0, 32'h44444444, tb_chk(32'h44444444));
    send(32'h55555555, 1'b1, 32'h55555555, tb_chk(32'h55555555));
    drain();
    check("bp_word_cnt", 64'(word_cnt), 64'd5);

    // injection
    arm(6'd5);
    check("inj_armed", 64'(inj_pending), 64'd1);
    send(32'h00000000, 1'b0, 32'h00000020, 8'h00);
    send(32'h00000000, 1'b0, 32'h00000000, 8'h00);
    drain();
    check("inj_cleared", 64'(inj_pending), 64'd0);
    arm(6'd33);
    send(32'h00000001, 1'b1, 32'h00000001, 8'h05);
    drain();
    arm(6'd50);
    send(32'h12345678, 1'b1, 32'h12345678, tb_chk(32'h12345678));
    drain();
    check("inj_none_cleared", 64'(inj_pending), 64'd0);

    // decoder loopback with random single injections
    for (int t = 0; t < 24; t++) begin
      d  = $urandom;
      en = 1'($urandom_range(0, 1));
      p  = 6'($urandom_range(0, 47));
      cw = {tb_chk(d), d};
      if (p < 6'd40) cw[p] = ~cw[p];
      arm(p);
      send(d, en, cw[31:0], cw[39:32]);
      drain();
    end

    // counter wrap
    reset = 1'b1;
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 65536; i++) begin
      d = i;
      send(d, d[0], d, tb_chk(d));
    end
    drain();
    check("cnt_wrap", 64'(word_cnt), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
